// File: rtl/wb_downsizer.sv
// rtl/wb_downsizer.sv - Wishbone wide-to-narrow downsizer, one wide access split into RATIO ascending narrow beats
// Optional feature: define WB_DOWNSIZER_SPARSE_EN to skip write beats whose byte-select slice is all zero.
module wb_downsizer #(
    parameter int WIDE_W   = 128,
    parameter int NARROW_W = 32,
    parameter int ADDR_W   = 16,
    localparam int RATIO   = WIDE_W / NARROW_W,
    localparam int BW      = $clog2(RATIO)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_cyc_i,
    input  logic                    s_stb_i,
    input  logic                    s_we_i,
    input  logic [ADDR_W-1:0]       s_adr_i,
    input  logic [WIDE_W-1:0]       s_dat_i,
    input  logic [WIDE_W/8-1:0]     s_sel_i,
    output logic [WIDE_W-1:0]       s_dat_o,
    output logic                    s_ack_o,
    output logic                    s_err_o,
    output logic                    m_cyc_o,
    output logic                    m_stb_o,
    output logic                    m_we_o,
    output logic [ADDR_W+BW-1:0]    m_adr_o,
    output logic [NARROW_W-1:0]     m_dat_o,
    output logic [NARROW_W/8-1:0]   m_sel_o,
    input  logic [NARROW_W-1:0]     m_dat_i,
    input  logic                    m_ack_i,
    input  logic                    m_err_i,
    input  logic                    m_rty_i
);
    localparam int NSEL = NARROW_W / 8;
    localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);

    typedef enum logic [1:0] {IDLE, BEAT, RESP} state_t;

    state_t                 state;
    logic [BW-1:0]          beat;
    logic [ADDR_W-1:0]      adr_q;
    logic [WIDE_W-1:0]      dat_q;
    logic [WIDE_W/8-1:0]    sel_q;
    logic                   we_q;
    logic [WIDE_W-1:0]      rbuf;

    logic [BW-1:0]          req_first;
    logic                   req_none;
    logic [BW-1:0]          nxt_beat;
    logic                   nxt_last;
    logic [WIDE_W-1:0]      rbuf_next;

    // Beat sequencing: which beat a new request starts on and where the current burst goes next.
    always_comb begin
        req_first = '0;
        req_none  = 1'b0;
        nxt_beat  = beat + BW'(1);
        nxt_last  = (beat == LAST_BEAT);
`ifdef WB_DOWNSIZER_SPARSE_EN
        if (s_we_i) begin
            req_none = 1'b1;
            for (int i = RATIO - 1; i >= 0; i--) begin
                if (|s_sel_i[i*NSEL +: NSEL]) begin
                    req_first = BW'(i);
                    req_none  = 1'b0;
                end
            end
        end
        if (we_q) begin
            nxt_last = 1'b1;
            for (int i = RATIO - 1; i >= 0; i--) begin
                if (i > int'(beat) && |sel_q[i*NSEL +: NSEL]) begin
                    nxt_beat = BW'(i);
                    nxt_last = 1'b0;
                end
            end
        end
`endif
        rbuf_next = rbuf;
        rbuf_next[beat*NARROW_W +: NARROW_W] = m_dat_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            beat    <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            rbuf    <= '0;
            s_dat_o <= '0;
            s_ack_o <= 1'b0;
            s_err_o <= 1'b0;
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            m_we_o  <= 1'b0;
            m_adr_o <= '0;
            m_dat_o <= '0;
            m_sel_o <= '0;
        end else begin
            s_ack_o <= 1'b0;
            s_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    // The cycle carrying s_err_o still sees the failed request on the slave bus.
                    if (s_cyc_i && s_stb_i && !s_err_o) begin
                        adr_q <= s_adr_i;
                        dat_q <= s_dat_i;
                        sel_q <= s_sel_i;
                        we_q  <= s_we_i;
                        beat  <= req_first;
                        if (req_none) begin
                            state   <= RESP;
                            s_ack_o <= 1'b1;
                        end else begin
                            state   <= BEAT;
                            m_cyc_o <= 1'b1;
                            m_stb_o <= 1'b1;
                            m_we_o  <= s_we_i;
                            m_adr_o <= {s_adr_i, req_first};
                            m_dat_o <= s_dat_i[req_first*NARROW_W +: NARROW_W];
                            m_sel_o <= s_sel_i[req_first*NSEL +: NSEL];
                        end
                    end
                end
                BEAT: begin
                    if (!s_cyc_i) begin
                        state   <= IDLE;
                        m_cyc_o <= 1'b0;
                        m_stb_o <= 1'b0;
                        m_we_o  <= 1'b0;
                    end else if (m_err_i) begin
                        state   <= IDLE;
                        s_err_o <= 1'b1;
                        m_cyc_o <= 1'b0;
                        m_stb_o <= 1'b0;
                        m_we_o  <= 1'b0;
                    end else if (m_ack_i) begin
                        if (!we_q) begin
                            rbuf <= rbuf_next;
                        end
                        if (nxt_last) begin
                            state   <= RESP;
                            s_ack_o <= 1'b1;
                            m_cyc_o <= 1'b0;
                            m_stb_o <= 1'b0;
                            m_we_o  <= 1'b0;
                            if (!we_q) begin
                                s_dat_o <= rbuf_next;
                            end
                        end else begin
                            beat    <= nxt_beat;
                            m_adr_o <= {adr_q, nxt_beat};
                            m_dat_o <= dat_q[nxt_beat*NARROW_W +: NARROW_W];
                            m_sel_o <= sel_q[nxt_beat*NSEL +: NSEL];
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
